// File: rtl/thread_regfile_mc.sv
// Per-thread register file with NUM_CONTEXTS resident blocks.
// Each context has its own registers, a per-register pending-load scoreboard
// and a latched %blockIdx. Deferred LSU writebacks may target any context.
// A sequential engine zeroes the writable registers of one context.
// Handshake semantics: there is no valid/ready back-pressure here. Every
// *_valid, *_req and ldr_issue input is a single-cycle command sampled on the
// clock edge while enable is high, and clear_req is dropped while clear_busy is set.
module thread_regfile_mc #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8,
    parameter int NUM_CONTEXTS      = 4,
    parameter int NUM_REGS          = 16,
    parameter int CTX_BITS          = $clog2(NUM_CONTEXTS),
    parameter int RA_BITS           = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CTX_BITS-1:0]     active_context,
    input  logic [2:0]              core_state,
    input  logic [RA_BITS-1:0]      decoded_rd_address,
    input  logic [RA_BITS-1:0]      decoded_rs_address,
    input  logic [RA_BITS-1:0]      decoded_rt_address,
    input  logic                    decoded_reg_write_enable,
    input  logic [1:0]              decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0]    decoded_immediate,
    input  logic [DATA_BITS-1:0]    alu_out,
    input  logic [DATA_BITS-1:0]    lsu_out,
    input  logic                    ldr_issue,
    input  logic                    launch_valid,
    input  logic [CTX_BITS-1:0]     launch_ctx,
    input  logic [7:0]              launch_block_id,
    input  logic                    wb_valid,
    input  logic [CTX_BITS-1:0]     wb_ctx,
    input  logic [RA_BITS-1:0]      wb_rd,
    input  logic [DATA_BITS-1:0]    wb_data,
    input  logic                    clear_req,
    input  logic [CTX_BITS-1:0]     clear_ctx,
    output logic                    clear_busy,
    output logic [NUM_CONTEXTS-1:0] ctx_ready,
    output logic                    wr_conflict,
    output logic [DATA_BITS-1:0]    rs,
    output logic [DATA_BITS-1:0]    rt
);

    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;
    // Highest writable register; the three above it are special read-only values.
    localparam logic [RA_BITS-1:0] LAST_WRITABLE = RA_BITS'(NUM_REGS - 4);
    localparam logic [RA_BITS-1:0] BLOCK_IDX_REG = RA_BITS'(NUM_REGS - 3);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    clear_state_t              clear_state;
    logic [CTX_BITS-1:0]       clear_idx_ctx;
    logic [RA_BITS-1:0]        clear_idx;

    logic [DATA_BITS-1:0]      regs    [NUM_CONTEXTS][NUM_REGS];
    logic [NUM_REGS-1:0]       pending [NUM_CONTEXTS];

    logic                      core_wr;
    logic [DATA_BITS-1:0]      core_wr_data;
    logic                      wb_wr;
    logic                      fwd_s;
    logic                      fwd_t;
    logic                      collide;
    logic                      ldr_set;

    // Decode this cycle's write sources, forwarding and collision detection.
    always_comb begin
        core_wr      = (core_state == ST_UPDATE) && decoded_reg_write_enable &&
                       (decoded_rd_address <= LAST_WRITABLE) &&
                       (decoded_reg_input_mux != 2'b11);
        core_wr_data = decoded_immediate;
        case (decoded_reg_input_mux)
            2'b00:   core_wr_data = alu_out;
            2'b01:   core_wr_data = lsu_out;
            default: core_wr_data = decoded_immediate;
        endcase
        wb_wr   = wb_valid && (wb_rd <= LAST_WRITABLE);
        fwd_s   = wb_wr && (wb_ctx == active_context) && (wb_rd == decoded_rs_address);
        fwd_t   = wb_wr && (wb_ctx == active_context) && (wb_rd == decoded_rt_address);
        collide = core_wr && wb_wr && (wb_ctx == active_context) &&
                  (wb_rd == decoded_rd_address);
        ldr_set = ldr_issue && (decoded_rd_address <= LAST_WRITABLE);
    end

    // Clear engine: walk R0..LAST_WRITABLE of the latched context, one per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_state   <= IDLE;
            clear_idx_ctx <= '0;
            clear_idx     <= '0;
        end else if (enable) begin
            case (clear_state)
                IDLE: begin
                    if (clear_req) begin
                        clear_state   <= CLEAR;
                        clear_idx_ctx <= clear_ctx;
                        clear_idx     <= '0;
                    end
                end
                CLEAR: begin
                    if (clear_idx == LAST_WRITABLE) begin
                        clear_state <= IDLE;
                    end else begin
                        clear_idx <= clear_idx + RA_BITS'(1);
                    end
                end
                default: clear_state <= IDLE;
            endcase
        end
    end

    // Storage, scoreboard and operand registers; later assignments take priority
    // (clear < core write < writeback; pending set by a new load beats any clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CONTEXTS; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (r == NUM_REGS - 2)
                        regs[c][r] <= DATA_BITS'(THREADS_PER_BLOCK);
                    else if (r == NUM_REGS - 1)
                        regs[c][r] <= DATA_BITS'(THREAD_ID);
                    else
                        regs[c][r] <= '0;
                end
                pending[c] <= '0;
            end
            rs          <= '0;
            rt          <= '0;
            wr_conflict <= 1'b0;
        end else if (enable) begin
            if (clear_state == CLEAR) begin
                regs[clear_idx_ctx][clear_idx]    <= '0;
                pending[clear_idx_ctx][clear_idx] <= 1'b0;
            end
            if (core_wr)
                regs[active_context][decoded_rd_address] <= core_wr_data;
            if (wb_wr) begin
                regs[wb_ctx][wb_rd]    <= wb_data;
                pending[wb_ctx][wb_rd] <= 1'b0;
            end
            if (launch_valid)
                regs[launch_ctx][BLOCK_IDX_REG] <= DATA_BITS'(launch_block_id);
            if (ldr_set)
                pending[active_context][decoded_rd_address] <= 1'b1;
            if (core_state == ST_REQUEST) begin
                rs <= fwd_s ? wb_data : regs[active_context][decoded_rs_address];
                rt <= fwd_t ? wb_data : regs[active_context][decoded_rt_address];
            end
            wr_conflict <= collide;
        end
    end

    assign clear_busy = (clear_state == CLEAR);

    // A context is ready when nothing is outstanding and it is not being cleared.
    for (genvar c = 0; c < NUM_CONTEXTS; c++) begin : g_ready
        assign ctx_ready[c] = ~|pending[c] &
                              ~(clear_busy && (clear_idx_ctx == CTX_BITS'(c)));
    end

endmodule

// File: tb/tb_thread_regfile_mc.sv
// Directed bench for thread_regfile_mc with a behavioural model compared every cycle.
module tb_thread_regfile_mc;

    localparam int NC = 4;
    localparam int NR = 16;
    localparam int DW = 8;
    localparam int TPB = 4;
    localparam int TID = 2;
    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          enable;
    logic [1:0]    active_context;
    logic [2:0]    core_state;
    logic [3:0]    decoded_rd_address;
    logic [3:0]    decoded_rs_address;
    logic [3:0]    decoded_rt_address;
    logic          decoded_reg_write_enable;
    logic [1:0]    decoded_reg_input_mux;
    logic [DW-1:0] decoded_immediate;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] lsu_out;
    logic          ldr_issue;
    logic          launch_valid;
    logic [1:0]    launch_ctx;
    logic [7:0]    launch_block_id;
    logic          wb_valid;
    logic [1:0]    wb_ctx;
    logic [3:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          clear_req;
    logic [1:0]    clear_ctx;
    logic          clear_busy;
    logic [NC-1:0] ctx_ready;
    logic          wr_conflict;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;

    thread_regfile_mc #(
        .THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .DATA_BITS(DW),
        .NUM_CONTEXTS(NC), .NUM_REGS(NR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .active_context(active_context), .core_state(core_state),
        .decoded_rd_address(decoded_rd_address),
        .decoded_rs_address(decoded_rs_address),
        .decoded_rt_address(decoded_rt_address),
        .decoded_reg_write_enable(decoded_reg_write_enable),
        .decoded_reg_input_mux(decoded_reg_input_mux),
        .decoded_immediate(decoded_immediate),
        .alu_out(alu_out), .lsu_out(lsu_out), .ldr_issue(ldr_issue),
        .launch_valid(launch_valid), .launch_ctx(launch_ctx),
        .launch_block_id(launch_block_id),
        .wb_valid(wb_valid), .wb_ctx(wb_ctx), .wb_rd(wb_rd), .wb_data(wb_data),
        .clear_req(clear_req), .clear_ctx(clear_ctx), .clear_busy(clear_busy),
        .ctx_ready(ctx_ready), .wr_conflict(wr_conflict), .rs(rs), .rt(rt)
    );

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    logic [DW-1:0] m_regs [NC][NR];
    logic [NR-1:0] m_pend [NC];
    int            clr_q[$];
    int            clr_ctx;
    logic [DW-1:0] m_rs, m_rt;
    logic          m_conf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] model_ready();
        logic [NC-1:0] r;
        for (int c = 0; c < NC; c++)
            r[c] = (m_pend[c] == '0) && !((clr_q.size() != 0) && (clr_ctx == c));
        return r;
    endfunction

    // Next-state model from the architectural rules, evaluated on current inputs.
    task automatic model_step();
        logic [DW-1:0] nr [NC][NR];
        logic [NR-1:0] np [NC];
        int ac, rd, r;
        bit core_w, wb_w;
        logic [DW-1:0] val;
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < NR; k++) m_regs[c][k] = '0;
                m_regs[c][NR-2] = DW'(TPB);
                m_regs[c][NR-1] = DW'(TID);
                m_pend[c] = '0;
            end
            clr_q.delete();
            clr_ctx = 0;
            m_rs = '0; m_rt = '0; m_conf = 1'b0;
            return;
        end
        if (!enable) return;
        nr = m_regs;
        np = m_pend;
        ac = int'(active_context);
        rd = int'(decoded_rd_address);
        wb_w   = wb_valid && (int'(wb_rd) < NR - 3);
        core_w = (core_state == UPD) && decoded_reg_write_enable && (rd < NR - 3) &&
                 (decoded_reg_input_mux != 2'b11);
        val = (decoded_reg_input_mux == 2'b00) ? alu_out :
              (decoded_reg_input_mux == 2'b01) ? lsu_out : decoded_immediate;
        if (core_state == REQ) begin
            m_rs = (wb_w && int'(wb_ctx) == ac && wb_rd == decoded_rs_address) ? wb_data
                   : m_regs[ac][decoded_rs_address];
            m_rt = (wb_w && int'(wb_ctx) == ac && wb_rd == decoded_rt_address) ? wb_data
                   : m_regs[ac][decoded_rt_address];
        end
        m_conf = core_w && wb_w && int'(wb_ctx) == ac && int'(wb_rd) == rd;
        if (clr_q.size() != 0) begin
            r = clr_q.pop_front();
            nr[clr_ctx][r] = '0;
            np[clr_ctx][r] = 1'b0;
        end else if (clear_req) begin
            for (int k = 0; k < NR - 3; k++) clr_q.push_back(k);
            clr_ctx = int'(clear_ctx);
        end
        if (core_w) nr[ac][rd] = val;
        if (wb_w) begin
            nr[wb_ctx][wb_rd] = wb_data;
            np[wb_ctx][wb_rd] = 1'b0;
        end
        if (launch_valid) nr[launch_ctx][NR-3] = DW'(launch_block_id);
        if (ldr_issue && rd < NR - 3) np[ac][rd] = 1'b1;
        m_regs = nr;
        m_pend = np;
    endtask

    // one clock: advance model, take the edge, compare every output
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("rs", rs, m_rs);
        check("rt", rt, m_rt);
        check("ctx_ready", ctx_ready, model_ready());
        check("clear_busy", clear_busy, clr_q.size() != 0);
        check("wr_conflict", wr_conflict, m_conf);
    endtask

    // driver tasks
    task automatic idle_inputs();
        core_state = 3'b000; decoded_reg_write_enable = 1'b0; decoded_reg_input_mux = 2'b11;
        ldr_issue = 1'b0; launch_valid = 1'b0; wb_valid = 1'b0; clear_req = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] c, input logic [3:0] sa, input logic [3:0] ta);
        active_context = c; core_state = REQ;
        decoded_rs_address = sa; decoded_rt_address = ta;
        tick();
        core_state = 3'b000;
    endtask

    task automatic do_write(input logic [1:0] c, input logic [3:0] d, input logic [1:0] mux,
                            input logic [DW-1:0] v);
        active_context = c; core_state = UPD; decoded_reg_write_enable = 1'b1;
        decoded_rd_address = d; decoded_reg_input_mux = mux;
        decoded_immediate = v; alu_out = v; lsu_out = v;
        tick();
        idle_inputs();
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b1; active_context = '0;
        decoded_rd_address = '0; decoded_rs_address = '0; decoded_rt_address = '0;
        decoded_immediate = '0; alu_out = '0; lsu_out = '0;
        launch_ctx = '0; launch_block_id = '0; wb_ctx = '0; wb_rd = '0; wb_data = '0;
        clear_ctx = '0;
        idle_inputs();
        tick();
        tick();
        check("reset_rs", rs, 8'h00);
        check("reset_ready", ctx_ready, 4'b1111);
        check("reset_busy", clear_busy, 1'b0);
        reset = 1'b0;

        // special registers after reset
        do_read(2'd3, 4'd15, 4'd14);
        check("tid_rs", rs, 8'h02);
        check("bdim_rt", rt, 8'h04);

        // launch and per-context isolation
        launch_valid = 1'b1; launch_ctx = 2'd1; launch_block_id = 8'h5A;
        tick();
        launch_valid = 1'b0;
        do_write(2'd1, 4'd3, 2'b10, 8'h07);
        do_read(2'd0, 4'd3, 4'd13);
        check("ctx0_r3", rs, 8'h00);
        check("ctx0_bidx", rt, 8'h00);
        do_read(2'd1, 4'd3, 4'd13);
        check("ctx1_r3", rs, 8'h07);
        check("ctx1_bidx", rt, 8'h5A);

        // scoreboard and out-of-order writeback
        active_context = 2'd2; decoded_rd_address = 4'd4; ldr_issue = 1'b1;
        tick();
        ldr_issue = 1'b0;
        check("ldr_ready", ctx_ready, 4'b1011);
        active_context = 2'd0; wb_valid = 1'b1; wb_ctx = 2'd2; wb_rd = 4'd4; wb_data = 8'h33;
        tick();
        wb_valid = 1'b0;
        check("wb_ready", ctx_ready, 4'b1111);
        do_read(2'd2, 4'd4, 4'd0);
        check("wb_data", rs, 8'h33);

        // forwarding on REQUEST
        wb_valid = 1'b1; wb_ctx = 2'd0; wb_rd = 4'd1; wb_data = 8'h11;
        do_read(2'd0, 4'd1, 4'd2);
        wb_valid = 1'b0;
        check("fwd_rs", rs, 8'h11);

        // core write vs writeback collision
        wb_valid = 1'b1; wb_ctx = 2'd0; wb_rd = 4'd2; wb_data = 8'h44;
        do_write(2'd0, 4'd2, 2'b00, 8'h22);
        check("conflict_pulse", wr_conflict, 1'b1);
        tick();
        check("conflict_drop", wr_conflict, 1'b0);
        do_read(2'd0, 4'd2, 4'd1);
        check("collide_r2", rs, 8'h44);

        // load issue and writeback to the same register: pending stays set
        active_context = 2'd0; decoded_rd_address = 4'd5; ldr_issue = 1'b1;
        wb_valid = 1'b1; wb_ctx = 2'd0; wb_rd = 4'd5; wb_data = 8'h55;
        tick();
        ldr_issue = 1'b0;
        check("ldr_wins", ctx_ready, 4'b1110);
        tick();
        wb_valid = 1'b0;
        check("ldr_done", ctx_ready, 4'b1111);

        // clear engine on ctx1, with an ignored second request mid-way
        do_write(2'd1, 4'd0, 2'b10, 8'hA0);
        do_write(2'd1, 4'd12, 2'b01, 8'hAC);
        clear_req = 1'b1; clear_ctx = 2'd1;
        tick();
        clear_req = 1'b0;
        check("clear_ready", ctx_ready, 4'b1101);
        n = 0;
        while (clear_busy && n < 40) begin
            n++;
            if (n == 5) begin clear_req = 1'b1; clear_ctx = 2'd2; end
            tick();
            clear_req = 1'b0;
        end
        check("clear_cycles", n, 13);
        check("clear_done_ready", ctx_ready, 4'b1111);
        do_read(2'd1, 4'd0, 4'd12);
        check("clr_r0", rs, 8'h00);
        check("clr_r12", rt, 8'h00);
        do_read(2'd1, 4'd13, 4'd14);
        check("clr_bidx", rs, 8'h5A);
        check("clr_bdim", rt, 8'h04);
        do_read(2'd2, 4'd4, 4'd15);
        check("ctx2_kept", rs, 8'h33);
        check("ctx2_tid", rt, 8'h02);

        // read-only registers ignore core writes and writeback
        do_write(2'd0, 4'd14, 2'b10, 8'h09);
        wb_valid = 1'b1; wb_ctx = 2'd0; wb_rd = 4'd15; wb_data = 8'hEE;
        tick();
        wb_valid = 1'b0;
        do_read(2'd0, 4'd14, 4'd15);
        check("ro_bdim", rs, 8'h04);
        check("ro_tid", rt, 8'h02);

        // enable low freezes everything, including writeback and operand capture
        enable = 1'b0;
        wb_valid = 1'b1; wb_ctx = 2'd0; wb_rd = 4'd6; wb_data = 8'h66;
        do_read(2'd0, 4'd2, 4'd6);
        wb_valid = 1'b0;
        check("hold_rs", rs, 8'h04);
        check("hold_rt", rt, 8'h02);
        enable = 1'b1;
        do_read(2'd0, 4'd6, 4'd2);
        check("frozen_wb", rs, 8'h00);
        check("r2_still", rt, 8'h44);

        // reset aborts a running clear
        clear_req = 1'b1; clear_ctx = 2'd0;
        tick();
        clear_req = 1'b0;
        tick();
        check("clear_running", clear_busy, 1'b1);
        reset = 1'b1;
        tick();
        check("abort_busy", clear_busy, 1'b0);
        check("abort_ready", ctx_ready, 4'b1111);
        reset = 1'b0;
        tick();
        check("abort_idle", clear_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/thread_regfile_mc.md
Name: thread_regfile_mc

Overview:
- Per-thread register file supporting NUM_CONTEXTS resident blocks, generalising the two-context register file.
- Adds per-context block-ID latching at launch and out-of-order LSU writeback into any context, not only the active one.
- Adds a per-register pending-load scoreboard driving per-context ready flags, and a sequential context-clear engine.
- One instance per thread slot inside each core; the scheduler uses ctx_ready to pick the next context to run.

Parameters:
THREADS_PER_BLOCK, 4, value of read-only %blockDim.
THREAD_ID, 0, value of read-only %threadIdx.
DATA_BITS, 8, register width; 8..32.
NUM_CONTEXTS, 4, resident contexts; power of 2, 2..8.
NUM_REGS, 16, registers per context; power of 2, 8..32.
CTX_BITS, $clog2(NUM_CONTEXTS), derived; do not override.
RA_BITS, $clog2(NUM_REGS), derived; do not override.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  thread slot active; 0 freezes all state except reset
active_context  in  CTX_BITS  context currently executing
core_state  in  3  3'b011 REQUEST, 3'b110 UPDATE
decoded_rd_address  in  RA_BITS  destination register
decoded_rs_address  in  RA_BITS  source register s
decoded_rt_address  in  RA_BITS  source register t
decoded_reg_write_enable  in  1  core writeback enable
decoded_reg_input_mux  in  2  00 ALU, 01 LSU, 10 CONST, 11 no write
decoded_immediate  in  DATA_BITS  CONST value
alu_out  in  DATA_BITS  ALU result
lsu_out  in  DATA_BITS  synchronous LSU result (mux 01)
ldr_issue  in  1  LDR sent to memory; marks (active_context, rd) pending
launch_valid  in  1  block launched into launch_ctx
launch_ctx  in  CTX_BITS  target context for launch
launch_block_id  in  8  %blockIdx for the launched block
wb_valid  in  1  deferred LSU writeback
wb_ctx  in  CTX_BITS  writeback context
wb_rd  in  RA_BITS  writeback register
wb_data  in  DATA_BITS  writeback data
clear_req  in  1  start clearing writable registers of clear_ctx
clear_ctx  in  CTX_BITS  context to clear
clear_busy  out  1  clear engine running
ctx_ready  out  NUM_CONTEXTS  bit c = 1 when context c has no pending loads and is not being cleared
wr_conflict  out  1  one-cycle pulse: core write and wb hit the same register
rs  out  DATA_BITS  source s operand
rt  out  DATA_BITS  source t operand

Behaviour:
- Register map per context: R0..R(NUM_REGS-4) writable; R(NUM_REGS-3) = %blockIdx, R(NUM_REGS-2) = %blockDim, R(NUM_REGS-1) = %threadIdx. All three are read-only to core writes and wb.
- Reset (synchronous, priority over enable):
  - All registers 0; blockDim = THREADS_PER_BLOCK and threadIdx = THREAD_ID in every context.
  - rs = rt = 0; pending bits 0; clear_busy = 0; wr_conflict = 0; ctx_ready = all ones.
  - A reset during an active clear aborts the clear.
- Launch: launch_valid writes launch_block_id (zero-extended) into %blockIdx of launch_ctx on the next edge. It is the only writer of %blockIdx.
- REQUEST: on the edge, rs and rt take registers[active_context][addr], with 1-cycle latency. If wb in the same cycle targets (active_context, addr), that operand takes wb_data (forwarded). Outside REQUEST, rs and rt hold their values.
- UPDATE: if write_enable, rd is writable and mux != 11, register[active_context][rd] takes the mux-selected value. Writes to a read-only rd are silently dropped.
- wb_valid: writes wb_data into [wb_ctx][wb_rd] if wb_rd is writable, and clears that register's pending bit. This occurs independent of core_state.
- Same-cycle collision between an UPDATE write and wb on the same (ctx, reg): wb data wins and wr_conflict pulses high for 1 cycle. Otherwise wr_conflict = 0.
- Scoreboard:
  - ldr_issue sets pending[active_context][decoded_rd_address] for writable rd only.
  - If ldr_issue and wb hit the same register in the same cycle, the set wins: the data is written and the pending bit stays set.
  - ctx_ready[c] = ~|pending[c] & ~(clear_busy & clear_idx_ctx == c); it is a registered-state function with no added latency.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req; latch clear_ctx and set index = 0.
  - In CLEAR, zero one register per cycle at the index and increment.
  - After writing index NUM_REGS-4, return to IDLE. A full clear takes exactly NUM_REGS-3 cycles; clear_busy is high for those cycles.
  - Each cleared register also has its pending bit cleared.
  - clear_req while busy is ignored.
  - A core write or wb to the register being cleared in the same cycle wins over the clear.
- enable = 0 blocks all updates, including wb, launch and clear progress. Outputs hold.

Test Plan:
- Reset with THREAD_ID=2 -> REQUEST rs=R15, rt=R14 in ctx 3 gives rs=2, rt=4; ctx_ready=4'b1111.
- Launch ctx1 with block_id 0x5A; CONST R3=7 in ctx1; switch to ctx0 and read R3, R13 -> 0, 0; switch to ctx1 -> 7, 0x5A.
- ldr_issue on ctx2 R4 -> ctx_ready=4'b1011; wb ctx2 R4 = 0x33 while ctx0 is active -> ctx_ready=4'b1111; ctx2 R4 reads 0x33.
- In the same cycle, REQUEST on ctx0 R1 and wb ctx0 R1 = 0x11 -> rs=0x11. In the same cycle, UPDATE ALU R2=0x22 and wb R2=0x44 -> R2=0x44 and wr_conflict pulses 1 cycle.
- clear_req ctx1 with NUM_REGS=16 -> clear_busy high 13 cycles; ctx1 R0..R12 read 0 and R13..R15 are unchanged; a second clear_req mid-clear is ignored.
- CONST to R14 -> R14 stays 4; reset asserted mid-clear -> clear_busy=0 on the next cycle.
